// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: data width, opcode constants and the arbiter FSM encoding.
package alu_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  // Opcodes understood by the external ALU; anything with bit 3 set is illegal.
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7
  } alu_op_e;

  // Arbiter control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Opcodes 8..15 are outside the ALU's instruction set.
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way grant logic: a lone requester always wins; on contention the pointer
// picks the winner in round-robin mode, requester 0 wins in fixed-priority mode.
module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic ptr_i,
  output logic grant0_o,
  output logic grant1_o
);

  // One-hot (or empty) grant derived only from the valids and the pointer.
  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    if (valid0_i && valid1_i) begin
      if (RR_EN && ptr_i) grant1_o = 1'b1;
      else                grant0_o = 1'b1;
    end else begin
      grant0_o = valid0_i;
      grant1_o = valid1_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters. A request is
// accepted in IDLE, its operands are presented to the ALU for one ISSUE cycle,
// and the result is held in RESP until the consumer takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_z,
  output logic              rsp_err
);

  state_e              state_q, state_d;
  logic                ptr_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                id_q;
  logic                rsp_id_q, rsp_z_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                grant0, grant1;
  logic                accept0, accept1, accept;
  logic                illegal;

  rr_arb2 #(.RR_EN(RR_EN)) u_rr_arb2 (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .ptr_i    (ptr_q),
    .grant0_o (grant0),
    .grant1_o (grant1)
  );

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;
  assign accept  = accept0 || accept1;
  assign illegal = is_illegal_op(op_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: one ISSUE cycle per accept, RESP holds until consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_ISSUE;
      ST_ISSUE:                state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Outputs: ready only in IDLE (and never while reset is held), ALU bus zero in IDLE.
  always_comb begin
    req0_ready = rst_n && (state_q == ST_IDLE) && grant0;
    req1_ready = rst_n && (state_q == ST_IDLE) && grant1;
    rsp_valid  = (state_q == ST_RESP);
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (state_q != ST_IDLE) begin
      alu_opcode = op_q;
      alu_a      = a_q;
      alu_b      = b_q;
    end
  end

  // Capture the winning request and advance the round-robin pointer past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= 1'b0;
      ptr_q <= 1'b0;
    end else if (accept) begin
      op_q  <= accept1 ? req1_opcode : req0_opcode;
      a_q   <= accept1 ? req1_a      : req0_a;
      b_q   <= accept1 ? req1_b      : req0_b;
      id_q  <= accept1;
      ptr_q <= RR_EN ? accept0 : 1'b0;
    end
  end

  // Latch the ALU result when leaving ISSUE; illegal opcodes report a zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_z_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (state_q == ST_ISSUE) begin
      rsp_id_q   <= id_q;
      rsp_err_q  <= illegal;
      rsp_data_q <= illegal ? '0 : alu_result;
      rsp_z_q    <= illegal ? 1'b1 : (alu_result == '0);
    end
  end

  assign rsp_id   = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_z    = rsp_z_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin instance and one fixed-priority
// instance share the requester inputs, each with its own ALU model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req1_valid, rsp_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;

  logic        r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_rsp_z, r_rsp_err;
  logic [3:0]  r_alu_opcode;
  logic [15:0] r_alu_a, r_alu_b, r_alu_result, r_rsp_data;
  logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_z, f_rsp_err;
  logic [3:0]  f_alu_opcode;
  logic [15:0] f_alu_a, f_alu_b, f_alu_result, f_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_SHL:  return a << b[3:0];
      OP_SHR:  return a >> b[3:0];
      default: return 16'hFFFF;
    endcase
  endfunction

  assign r_alu_result = alu_model(r_alu_opcode, r_alu_a, r_alu_b);
  assign f_alu_result = alu_model(f_alu_opcode, f_alu_a, f_alu_b);

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r_req0_ready), .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(r_req1_ready), .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(r_alu_opcode), .alu_a(r_alu_a), .alu_b(r_alu_b), .alu_result(r_alu_result),
    .rsp_valid(r_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(r_rsp_id), .rsp_data(r_rsp_data),
    .rsp_z(r_rsp_z), .rsp_err(r_rsp_err)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(f_alu_opcode), .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_result(f_alu_result),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id), .rsp_data(f_rsp_data),
    .rsp_z(f_rsp_z), .rsp_err(f_rsp_err)
  );

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    n_checks++; if ({r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_rsp_z, r_rsp_err} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_rsp_z, r_rsp_err}); end
    n_checks++; if ({r_rsp_data, r_alu_opcode, r_alu_a, r_alu_b} !== 52'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {r_rsp_data, r_alu_opcode, r_alu_a, r_alu_b}); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if ({r_req0_ready, r_req1_ready} !== 2'b10) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 10", {r_req0_ready, r_req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_opcode = OP_ADD; req0_a = 16'h0003; req0_b = 16'h0004; #1;
    n_checks++; if (r_req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", r_req0_ready); end
    @(negedge clk); req0_valid = 1'b0;
    n_checks++; if (r_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_issue_valid: got %b expected 0", r_rsp_valid); end
    n_checks++; if ({r_alu_opcode, r_alu_a, r_alu_b} !== {4'h0, 16'h0003, 16'h0004}) begin n_fail++; $display("FAIL single_alu_bus: got %h expected 0_0003_0004", {r_alu_opcode, r_alu_a, r_alu_b}); end
    @(negedge clk);
    n_checks++; if ({r_rsp_valid, r_rsp_id, r_rsp_z, r_rsp_err, r_rsp_data} !== {4'b1000, 16'h0007}) begin n_fail++; $display("FAIL single_rsp: got v%b id%b z%b e%b d%h expected v1 id0 z0 e0 d0007", r_rsp_valid, r_rsp_id, r_rsp_z, r_rsp_err, r_rsp_data); end
    @(negedge clk);
    n_checks++; if ({r_rsp_valid, r_alu_a} !== 17'h0) begin n_fail++; $display("FAIL single_idle: got v%b alu_a %h expected v0 0000", r_rsp_valid, r_alu_a); end
    $display("test_single done");
  endtask

  task automatic test_ops();
    logic [3:0]  ops [4];
    logic [15:0] av [4];
    logic [15:0] bv [4];
    logic [15:0] ev [4];
    ops = '{OP_AND, OP_NOT, OP_SHL, OP_SHR};
    av  = '{16'hF0F0, 16'h00FF, 16'h0001, 16'h8000};
    bv  = '{16'hFF00, 16'h1234, 16'h0004, 16'h000F};
    ev  = '{16'hF000, 16'hFF00, 16'h0010, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req1_valid = 1'b1; req1_opcode = ops[i]; req1_a = av[i]; req1_b = bv[i];
      @(negedge clk); req1_valid = 1'b0;
      @(negedge clk);
      n_checks++; if ({r_rsp_valid, r_rsp_id, r_rsp_data} !== {2'b11, ev[i]}) begin n_fail++; $display("FAIL ops_%0d: got v%b id%b d%h expected v1 id1 d%h", i, r_rsp_valid, r_rsp_id, r_rsp_data, ev[i]); end
      @(negedge clk);
    end
    $display("test_ops done");
  endtask

  task automatic test_contention();
    int g [3];
    int ng = 0;
    int nr = 0;
    @(negedge clk);
    req0_valid = 1'b1; req0_opcode = OP_SUB; req0_a = 16'h0005; req0_b = 16'h0005;
    req1_valid = 1'b1; req1_opcode = OP_OR;  req1_a = 16'h00F0; req1_b = 16'h000F;
    for (int i = 0; i < 9; i++) begin
      #1;
      n_checks++; if (r_req0_ready && r_req1_ready) begin n_fail++; $display("FAIL cont_onehot: got ready 11 expected at most one"); end
      if (r_req0_ready) begin if (ng < 3) g[ng] = 0; ng++; end
      else if (r_req1_ready) begin if (ng < 3) g[ng] = 1; ng++; end
      if (r_rsp_valid) begin
        nr++;
        if (r_rsp_id == 1'b0) begin
          n_checks++; if ({r_rsp_z, r_rsp_data} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL cont_rsp0: got z%b d%h expected z1 d0000", r_rsp_z, r_rsp_data); end
        end else begin
          n_checks++; if ({r_rsp_z, r_rsp_data} !== {1'b0, 16'h00FF}) begin n_fail++; $display("FAIL cont_rsp1: got z%b d%h expected z0 d00ff", r_rsp_z, r_rsp_data); end
        end
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if (ng !== 3) begin n_fail++; $display("FAIL cont_grant_count: got %0d expected 3", ng); end
    else begin
      n_checks++; if ({g[0], g[1], g[2]} !== {32'd0, 32'd1, 32'd0}) begin n_fail++; $display("FAIL cont_grant_order: got %0d,%0d,%0d expected 0,1,0", g[0], g[1], g[2]); end
    end
    n_checks++; if (nr !== 3) begin n_fail++; $display("FAIL cont_rsp_count: got %0d expected 3", nr); end
    $display("test_contention done");
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req0_valid = 1'b1; req0_opcode = OP_ADD; req0_a = 16'h1234; req0_b = 16'h0001;
    req1_valid = 1'b0; rsp_ready = 1'b0; #1;
    n_checks++; if (r_req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: got %b expected 1", r_req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_opcode = OP_XOR; req1_a = 16'h00FF; req1_b = 16'h0F0F; #1;
    n_checks++; if (r_req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_issue_ready1: got %b expected 0", r_req1_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if ({r_rsp_valid, r_rsp_id, r_rsp_z, r_rsp_err, r_rsp_data, r_req1_ready} !== {4'b1000, 16'h1235, 1'b0}) begin n_fail++; $display("FAIL bp_hold_%0d: got v%b id%b z%b e%b d%h r1%b expected v1 id0 z0 e0 d1235 r1 0", k, r_rsp_valid, r_rsp_id, r_rsp_z, r_rsp_err, r_rsp_data, r_req1_ready); end
      if (k == 4) rsp_ready = 1'b1;
    end
    @(negedge clk);
    n_checks++; if ({r_rsp_valid, r_req1_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_after_consume: got v%b r1%b expected v0 r1 1", r_rsp_valid, r_req1_ready); end
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({r_rsp_valid, r_rsp_id, r_rsp_data} !== {2'b11, 16'h0FF0}) begin n_fail++; $display("FAIL bp_rsp1: got v%b id%b d%h expected v1 id1 d0ff0", r_rsp_valid, r_rsp_id, r_rsp_data); end
    @(negedge clk);
    $display("test_backpressure done");
  endtask

  task automatic test_illegal();
    @(negedge clk);
    req0_valid = 1'b1; req0_opcode = 4'hA; req0_a = 16'hFFFF; req0_b = 16'h0001;
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({r_rsp_valid, r_rsp_err, r_rsp_z, r_rsp_data} !== {3'b111, 16'h0000}) begin n_fail++; $display("FAIL illegal_rsp: got v%b e%b z%b d%h expected v1 e1 z1 d0000", r_rsp_valid, r_rsp_err, r_rsp_z, r_rsp_data); end
    @(negedge clk);
    $display("test_illegal done");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    req1_valid = 1'b1; req1_opcode = OP_ADD; req1_a = 16'h0010; req1_b = 16'h0020; rsp_ready = 1'b0;
    @(negedge clk); req1_valid = 1'b0; req0_valid = 1'b1; req0_opcode = OP_ADD; req0_a = 16'h0100; req0_b = 16'h0001;
    @(negedge clk);
    n_checks++; if ({r_rsp_valid, r_rsp_data} !== {1'b1, 16'h0030}) begin n_fail++; $display("FAIL rmid_pre: got v%b d%h expected v1 d0030", r_rsp_valid, r_rsp_data); end
    #2 rst_n = 1'b0; #1;
    n_checks++; if ({r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_rsp_z, r_rsp_err} !== 6'b0) begin n_fail++; $display("FAIL rmid_ctrl: got %b expected 000000", {r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_rsp_z, r_rsp_err}); end
    n_checks++; if ({r_rsp_data, r_alu_opcode, r_alu_a, r_alu_b} !== 52'h0) begin n_fail++; $display("FAIL rmid_data: got %h expected 0", {r_rsp_data, r_alu_opcode, r_alu_a, r_alu_b}); end
    @(negedge clk); rst_n = 1'b1; req0_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (r_rsp_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rmid_no_rsp: got %0d responses expected 0", seen); end
    req0_valid = 1'b1; #1;
    n_checks++; if (r_req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", r_req0_ready); end
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({r_rsp_valid, r_rsp_id, r_rsp_data} !== {2'b10, 16'h0101}) begin n_fail++; $display("FAIL rmid_serve: got v%b id%b d%h expected v1 id0 d0101", r_rsp_valid, r_rsp_id, r_rsp_data); end
    @(negedge clk);
    $display("test_reset_mid done");
  endtask

  task automatic test_fixed();
    int g0 = 0;
    int g1 = 0;
    @(negedge clk);
    req0_valid = 1'b1; req0_opcode = OP_ADD; req0_a = 16'h0001; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_opcode = OP_SUB; req1_a = 16'h0009; req1_b = 16'h0002;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (f_req0_ready) g0++;
      if (f_req1_ready) g1++;
      if (f_rsp_valid) begin
        n_checks++; if ({f_rsp_id, f_rsp_data} !== {1'b0, 16'h0002}) begin n_fail++; $display("FAIL fixed_rsp: got id%b d%h expected id0 d0002", f_rsp_id, f_rsp_data); end
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if ({g0, g1} !== {32'd3, 32'd0}) begin n_fail++; $display("FAIL fixed_grants: got req0 %0d req1 %0d expected 3 and 0", g0, g1); end
    @(negedge clk);
    $display("test_fixed done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_ops();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_fixed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to requester 0.
REQ-002 SHALL have ports, each listed as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have per-requester ports for i = 0,1:
- req{i}_valid  in  1  request present.
- req{i}_ready  out  1  request accepted this cycle.
- req{i}_opcode  in  4  ALU opcode.
- req{i}_a  in  16  operand A.
- req{i}_b  in  16  operand B.
REQ-004 SHALL have shared-ALU ports:
- alu_opcode  out  4  opcode to ALU.
- alu_a  out  16  operand A to ALU.
- alu_b  out  16  operand B to ALU.
- alu_result  in  16  combinational ALU output.
REQ-005 SHALL have response ports:
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts.
- rsp_id  out  1  requester index.
- rsp_data  out  16  result.
- rsp_z  out  1  rsp_data == 0.
- rsp_err  out  1  opcode was 8..15.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, RESP, with transitions:
- IDLE -> ISSUE on an accepted request.
- ISSUE -> RESP unconditionally.
- RESP -> IDLE when rsp_ready=1.
- Otherwise the state holds.
REQ-007 SHALL compute req{i}_ready = (state==IDLE) && grant_i; a request is accepted when valid && ready on the same edge.
REQ-008 SHALL compute grant only from the valids and the priority pointer, and at most one grant SHALL be high in any cycle.
REQ-009 SHALL arbitrate in round-robin mode (RR_EN=1) as follows:
- Only one valid: that requester wins.
- Both valid: the requester indicated by the pointer wins.
- After each accept, the pointer moves to the other requester.
REQ-010 SHALL, in fixed-priority mode (RR_EN=0), always grant requester 0 when both are valid; the pointer is unused.
REQ-011 SHALL, on accept, register opcode, A, B and the winner index.
REQ-012 SHALL hold the alu_* outputs from those registers from ISSUE through RESP, and drive them to zero in IDLE.
REQ-013 SHALL, at the edge leaving ISSUE, capture rsp_data = alu_result, rsp_z = (alu_result==0) and rsp_err = opcode[3].
REQ-014 SHALL force rsp_data=0 and rsp_z=1 when rsp_err=1.
REQ-015 SHALL assert rsp_valid only in RESP, and SHALL hold rsp_id, rsp_data, rsp_z and rsp_err stable while rsp_valid=1 && rsp_ready=0.
REQ-016 SHALL have latency of exactly 1 cycle from accept to rsp_valid: accept at edge N gives rsp_valid=1 after edge N+1.
REQ-017 SHALL have a minimum interval of 3 cycles between accepts, with no accept in the same cycle a response is consumed.
REQ-018 SHALL ignore requester inputs outside IDLE, while requester valid remains asserted and waits.
REQ-019 SHALL block new requests on backpressure (rsp_ready=0) for as long as it persists, with no loss and no overwrite.
REQ-020 SHALL compute rsp_z internally and SHALL NOT depend on any ALU flag.

Reset
REQ-021 SHALL, while rst_n=0, immediately force:
- state = IDLE, pointer = 0.
- All response registers and operand registers = 0.
- All outputs = 0: req{i}_ready, rsp_valid, rsp_id, rsp_data, rsp_z, rsp_err and alu_*.
REQ-022 SHALL, on reset asserted mid-operation (ISSUE or RESP), drop the in-flight operation and produce no response after release.
REQ-023 SHALL leave the first cycle after rst_n rises in IDLE, able to accept requests.

Structure
REQ-024 SHALL take the opcode constants (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, SHR=7), the FSM state encodings and the 16-bit data width from the shared ALU package.
REQ-025 SHALL place the 2-way round-robin grant logic in one sub-module, rr_arb2; the FSM and registers stay in alu_arbiter, and the ALU remains external.

Verification
REQ-026 SHALL cover single request: req0 ADD A=0x0003 B=0x0004, with the ALU model connected:
- rsp_valid 1 cycle after accept.
- rsp_data=0x0007, rsp_id=0, rsp_z=0.
REQ-027 SHALL cover contention: both valid continuously with RR_EN=1 (req0 SUB 5-5, req1 OR 0x00F0|0x000F):
- Grants alternate 0,1,0.
- req0 response: rsp_z=1, data 0x0000.
- req1 response: data 0x00FF.
REQ-028 SHALL cover backpressure: rsp_ready=0 for 5 cycles while req1 is valid:
- rsp fields stay constant.
- req1_ready=0 throughout.
- req1 is accepted 1 cycle after the response is consumed.
REQ-029 SHALL cover illegal opcode: opcode 0xA, A=0xFFFF:
- rsp_err=1, rsp_data=0x0000, rsp_z=1.
REQ-030 SHALL cover reset during RESP: pulse rst_n low:
- All outputs 0 during the pulse.
- No rsp_valid after release.
- Next accepted request is served normally.
REQ-031 SHALL cover fixed priority: RR_EN=0 with both valid for 3 accepts:
- All 3 grants go to requester 0.
